// File: rtl/rx_symbol_packer.sv
// Packs decoded 8b/10b receive symbols into 8/16/32-bit PIPE words. It aligns on COM (K28.5),
// replaces errored symbols with EDB and reports a sticky status for each word.
module rx_symbol_packer (
  input  logic        Word_CLK,
  input  logic        Reset,
  input  logic [7:0]  Symbol_Data,
  input  logic        Symbol_K,
  input  logic        Symbol_Valid,
  input  logic        Decode_Err,
  input  logic        Disp_Err,
  input  logic [5:0]  DataBusWidth,
  output logic [31:0] Rx_Data,
  output logic [3:0]  Rx_DataK,
  output logic        Rx_Valid,
  output logic [2:0]  Rx_Status,
  output logic        Aligned
);

  typedef enum logic {UNALIGNED = 1'b0, ALIGNED = 1'b1} state_e;

  localparam logic [7:0] COM_BYTE = 8'hBC;
  localparam logic [7:0] EDB_BYTE = 8'hFE;
  localparam logic [2:0] ST_OK    = 3'b000;
  localparam logic [2:0] ST_DEC   = 3'b100;
  localparam logic [2:0] ST_DISP  = 3'b111;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  width_q, width_d;
  logic [2:0]  err_cnt_q, err_cnt_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [3:0]  buf_k_q, buf_k_d;
  logic [2:0]  buf_stat_q, buf_stat_d;
  logic [31:0] rx_data_q, rx_data_d;
  logic [3:0]  rx_k_q, rx_k_d;
  logic        rx_valid_q, rx_valid_d;
  logic [2:0]  rx_stat_q, rx_stat_d;

  logic        sym_err_s, is_com_s, realign_s, word_start_s, lose_s;
  logic [2:0]  w_eff_s, new_cnt_s, sym_stat_s, new_stat_s;
  logic [1:0]  idx_s;
  logic [31:0] new_data_s;
  logic [3:0]  new_k_s;

  function automatic logic [2:0] decode_width(input logic [5:0] w);
    case (w)
      6'd16:   return 3'd2;
      6'd32:   return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  // Decode error outranks disparity error; both outrank ok.
  function automatic logic [2:0] merge_status(input logic [2:0] a, input logic [2:0] b);
    if ((a == ST_DEC) || (b == ST_DEC)) begin
      return ST_DEC;
    end else if ((a == ST_DISP) || (b == ST_DISP)) begin
      return ST_DISP;
    end else begin
      return ST_OK;
    end
  endfunction

  // Next-state: symbol packing, alignment tracking and word emission.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    width_d    = width_q;
    err_cnt_d  = err_cnt_q;
    buf_data_d = buf_data_q;
    buf_k_d    = buf_k_q;
    buf_stat_d = buf_stat_q;
    rx_data_d  = rx_data_q;
    rx_k_d     = rx_k_q;
    rx_stat_d  = rx_stat_q;
    rx_valid_d = 1'b0;

    sym_err_s  = Decode_Err | Disp_Err;
    is_com_s   = (Symbol_Data == COM_BYTE) && Symbol_K && !sym_err_s;
    sym_stat_s = Decode_Err ? ST_DEC : (Disp_Err ? ST_DISP : ST_OK);
    // A COM in the last slot of a word is ordinary data, not a realignment.
    realign_s  = (state_q == ALIGNED) && is_com_s && (cnt_q != 3'd0) && (cnt_q != (width_q - 3'd1));
    lose_s     = (state_q == ALIGNED) && sym_err_s && (err_cnt_q == 3'd3);

    word_start_s = (cnt_q == 3'd0) || realign_s;
    w_eff_s      = word_start_s ? decode_width(DataBusWidth) : width_q;
    idx_s        = word_start_s ? 2'd0 : cnt_q[1:0];
    new_data_s   = word_start_s ? 32'd0 : buf_data_q;
    new_k_s      = word_start_s ? 4'd0 : buf_k_q;
    new_stat_s   = merge_status(word_start_s ? ST_OK : buf_stat_q, sym_stat_s);
    new_data_s[{idx_s, 3'b000} +: 8] = sym_err_s ? EDB_BYTE : Symbol_Data;
    new_k_s[idx_s] = sym_err_s | Symbol_K;
    new_cnt_s      = {1'b0, idx_s} + 3'd1;

    if (!Symbol_Valid || ((state_q == UNALIGNED) && !is_com_s)) begin
      state_d = state_q;
    end else if (lose_s) begin
      state_d   = UNALIGNED;
      cnt_d     = 3'd0;
      err_cnt_d = 3'd0;
    end else begin
      state_d    = ALIGNED;
      err_cnt_d  = sym_err_s ? (err_cnt_q + 3'd1) : 3'd0;
      width_d    = w_eff_s;
      buf_data_d = new_data_s;
      buf_k_d    = new_k_s;
      buf_stat_d = new_stat_s;
      if (new_cnt_s == w_eff_s) begin
        cnt_d      = 3'd0;
        rx_data_d  = new_data_s;
        rx_k_d     = new_k_s;
        rx_stat_d  = new_stat_s;
        rx_valid_d = 1'b1;
      end else begin
        cnt_d = new_cnt_s;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge Word_CLK or posedge Reset) begin
    if (Reset) begin
      state_q    <= UNALIGNED;
      cnt_q      <= 3'd0;
      width_q    <= 3'd1;
      err_cnt_q  <= 3'd0;
      buf_data_q <= 32'd0;
      buf_k_q    <= 4'd0;
      buf_stat_q <= 3'd0;
      rx_data_q  <= 32'd0;
      rx_k_q     <= 4'd0;
      rx_valid_q <= 1'b0;
      rx_stat_q  <= 3'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      width_q    <= width_d;
      err_cnt_q  <= err_cnt_d;
      buf_data_q <= buf_data_d;
      buf_k_q    <= buf_k_d;
      buf_stat_q <= buf_stat_d;
      rx_data_q  <= rx_data_d;
      rx_k_q     <= rx_k_d;
      rx_valid_q <= rx_valid_d;
      rx_stat_q  <= rx_stat_d;
    end
  end

  assign Rx_Data   = rx_data_q;
  assign Rx_DataK  = rx_k_q;
  assign Rx_Valid  = rx_valid_q;
  assign Rx_Status = rx_stat_q;
  assign Aligned   = (state_q == ALIGNED);

endmodule

// File: tb/tb_rx_symbol_packer.sv
// Scoreboard bench for rx_symbol_packer: a queue-based reference model predicts each word,
// and a negedge monitor compares every Rx_Valid word against the expected queue.
module tb_rx_symbol_packer;

  logic        Word_CLK = 1'b0;
  logic        Reset;
  logic [7:0]  Symbol_Data;
  logic        Symbol_K, Symbol_Valid, Decode_Err, Disp_Err;
  logic [5:0]  DataBusWidth;
  logic [31:0] Rx_Data;
  logic [3:0]  Rx_DataK;
  logic        Rx_Valid;
  logic [2:0]  Rx_Status;
  logic        Aligned;

  always #5 Word_CLK = ~Word_CLK;

  rx_symbol_packer dut (
    .Word_CLK(Word_CLK), .Reset(Reset), .Symbol_Data(Symbol_Data), .Symbol_K(Symbol_K),
    .Symbol_Valid(Symbol_Valid), .Decode_Err(Decode_Err), .Disp_Err(Disp_Err),
    .DataBusWidth(DataBusWidth), .Rx_Data(Rx_Data), .Rx_DataK(Rx_DataK),
    .Rx_Valid(Rx_Valid), .Rx_Status(Rx_Status), .Aligned(Aligned)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic [2:0]  s;
  } word_t;

  word_t      exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;

  bit         m_aligned;
  int         m_run;
  int         m_n;
  logic [7:0] m_bytes[$];
  logic       m_ks[$];
  logic [2:0] m_stat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_aligned = 1'b0;
    m_run = 0;
    m_n = 1;
    m_bytes.delete();
    m_ks.delete();
    m_stat = 3'b000;
  endtask

  // Reference behaviour: words are lists of bytes; push a finished word on the scoreboard.
  task automatic model_step(input logic [7:0] d, input logic k, input logic de, input logic pe,
                            input logic [5:0] w);
    bit    err, com;
    int    n;
    word_t wd;
    err = de | pe;
    com = (d == 8'hBC) && k && !err;
    n = (w == 6'd16) ? 2 : ((w == 6'd32) ? 4 : 1);
    if (!m_aligned) begin
      if (!com) return;
      m_aligned = 1'b1;
      m_run = 0;
      m_bytes.delete();
      m_ks.delete();
    end else if (err) begin
      m_run++;
      if (m_run == 4) begin
        model_reset();
        return;
      end
    end else begin
      m_run = 0;
    end
    if (m_bytes.size() == 0 || (com && m_bytes.size() != m_n - 1)) begin
      m_bytes.delete();
      m_ks.delete();
      m_n = n;
      m_stat = 3'b000;
    end
    m_bytes.push_back(err ? 8'hFE : d);
    m_ks.push_back(err ? 1'b1 : k);
    if (de) m_stat = 3'b100;
    else if (pe && m_stat != 3'b100) m_stat = 3'b111;
    if (m_bytes.size() == m_n) begin
      wd = '0;
      for (int i = 0; i < m_n; i++) begin
        wd.d[8*i +: 8] = m_bytes[i];
        wd.k[i] = m_ks[i];
      end
      wd.s = m_stat;
      exp_q.push_back(wd);
      m_bytes.delete();
      m_ks.delete();
    end
  endtask

  task automatic send(input logic [7:0] d, input logic k, input logic de = 1'b0,
                      input logic pe = 1'b0, input logic v = 1'b1);
    Symbol_Data = d;
    Symbol_K = k;
    Decode_Err = de;
    Disp_Err = pe;
    Symbol_Valid = v;
    @(posedge Word_CLK);
    if (v) model_step(d, k, de, pe, DataBusWidth);
    #1;
    chk("aligned", {31'd0, Aligned}, {31'd0, m_aligned});
    Symbol_Valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) send(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    model_reset();
    #1;
    chk("rst_data", Rx_Data, 32'd0);
    chk("rst_valid", {31'd0, Rx_Valid}, 32'd0);
    chk("rst_aligned", {31'd0, Aligned}, 32'd0);
    #3;
    Reset = 1'b0;
  endtask

  // Monitor: every emitted word must match the head of the expected queue.
  always @(negedge Word_CLK) begin
    word_t wd;
    if (!Reset && Rx_Valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got %h expected no word at %0t", Rx_Data, $time);
      end else begin
        wd = exp_q.pop_front();
        chk("sb_data", Rx_Data, wd.d);
        chk("sb_datak", {28'd0, Rx_DataK}, {28'd0, wd.k});
        chk("sb_status", {29'd0, Rx_Status}, {29'd0, wd.s});
      end
    end
  end

  initial begin
    int burst;
    logic [7:0] d;
    logic k, de, pe;
    Reset = 1'b1;
    Symbol_Data = 8'h00; Symbol_K = 1'b0; Symbol_Valid = 1'b0;
    Decode_Err = 1'b0; Disp_Err = 1'b0; DataBusWidth = 6'd32;
    model_reset();
    #12;
    chk("reset_data", Rx_Data, 32'd0);
    chk("reset_datak", {28'd0, Rx_DataK}, 32'd0);
    chk("reset_valid", {31'd0, Rx_Valid}, 32'd0);
    chk("reset_status", {29'd0, Rx_Status}, 32'd0);
    chk("reset_aligned", {31'd0, Aligned}, 32'd0);
    Reset = 1'b0;
    @(negedge Word_CLK);

    // Width 32 basic word
    send(8'hBC, 1'b1); send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
    chk("w32_valid", {31'd0, Rx_Valid}, 32'd1);
    chk("w32_data", Rx_Data, 32'h332211BC);
    chk("w32_datak", {28'd0, Rx_DataK}, 32'h1);
    chk("w32_status", {29'd0, Rx_Status}, 32'd0);
    idle(1);
    chk("w32_pulse", {31'd0, Rx_Valid}, 32'd0);
    chk("w32_hold", Rx_Data, 32'h332211BC);
    idle(1);

    // Width 16, leading symbols dropped while unaligned
    do_reset();
    DataBusWidth = 6'd16;
    send(8'h01, 1'b0); send(8'h02, 1'b0);
    send(8'hBC, 1'b1); send(8'hAA, 1'b0);
    chk("w16_a", Rx_Data, 32'h0000AABC);
    chk("w16_ak", {28'd0, Rx_DataK}, 32'h1);
    send(8'h55, 1'b0); send(8'h66, 1'b0);
    chk("w16_b", Rx_Data, 32'h00006655);
    chk("w16_bk", {28'd0, Rx_DataK}, 32'h0);

    // Width 8 error substitution
    DataBusWidth = 6'd8;
    send(8'h7C, 1'b0, 1'b1, 1'b1);
    chk("edb_data", Rx_Data, 32'h000000FE);
    chk("edb_k", {28'd0, Rx_DataK}, 32'h1);
    chk("edb_status", {29'd0, Rx_Status}, 32'h4);
    send(8'h33, 1'b0);
    chk("after_edb_status", {29'd0, Rx_Status}, 32'h0);

    // Realignment, then loss of alignment
    DataBusWidth = 6'd32;
    send(8'hBC, 1'b1); send(8'h11, 1'b0);
    send(8'hBC, 1'b1); send(8'h44, 1'b0); send(8'h55, 1'b0); send(8'h66, 1'b0);
    chk("realign_data", Rx_Data, 32'h665544BC);
    for (int i = 0; i < 4; i++) send(8'h12, 1'b0, 1'b0, 1'b1);
    chk("lost_aligned", {31'd0, Aligned}, 32'd0);
    send(8'h10, 1'b0); send(8'h20, 1'b0); send(8'h30, 1'b0); send(8'h40, 1'b0);

    // Width change mid-word, then illegal width
    send(8'hBC, 1'b1); send(8'h11, 1'b0);
    DataBusWidth = 6'd8;
    send(8'h22, 1'b0); send(8'h33, 1'b0);
    chk("wchg_word", Rx_Data, 32'h332211BC);
    send(8'h44, 1'b0);
    chk("wchg_byte", Rx_Data, 32'h00000044);
    DataBusWidth = 6'd20;
    send(8'h55, 1'b0);
    chk("illegal_width", Rx_Data, 32'h00000055);

    // Reset mid-word
    DataBusWidth = 6'd32;
    idle(1);
    send(8'hBC, 1'b1); send(8'h01, 1'b0); send(8'h02, 1'b0);
    #2;
    do_reset();
    send(8'h44, 1'b0);
    send(8'hBC, 1'b1); send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
    chk("post_reset_word", Rx_Data, 32'h030201BC);

    // Randomized traffic against the model
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 4))
          0: DataBusWidth = 6'd8;
          1: DataBusWidth = 6'd16;
          2: DataBusWidth = 6'd32;
          3: DataBusWidth = 6'd20;
          default: DataBusWidth = 6'($urandom_range(0, 63));
        endcase
      end
      if (burst == 0 && $urandom_range(0, 99) == 0) burst = $urandom_range(3, 5);
      if ($urandom_range(0, 99) < 20) begin
        d = 8'hBC; k = 1'b1;
      end else begin
        d = 8'($urandom_range(0, 255)); k = ($urandom_range(0, 9) == 0);
      end
      de = 1'b0; pe = 1'b0;
      if (burst > 0 || $urandom_range(0, 99) < 6) begin
        de = 1'($urandom_range(0, 1));
        pe = !de || 1'($urandom_range(0, 1));
        if (burst > 0) burst--;
      end
      send(d, k, de, pe, ($urandom_range(0, 99) < 85));
    end

    idle(3);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
